// File: rtl/lt_inverse_seq.sv
// Sequential inverse of an N x N unit-lower-triangular fixed-point matrix.
// Forward substitution on one shared MAC: one product per enabled cycle, row-major entry order.
module lt_inverse_seq #(
  parameter int N     = 6,
  parameter int W     = 27,
  parameter int FRAC  = 16,
  parameter int GUARD = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             start,
  input  logic [N*N*W-1:0] matrix,
  output logic             busy,
  output logic             done,
  output logic [N*N*W-1:0] lt_inverse,
  output logic             ovf
);

  // state | meaning
  // IDLE  | waiting for start; result held
  // CALC  | one MAC for entry (i,j): acc += L[i][k]*X[k][j]
  // WRITE | X[i][j] = sat(-acc), advance to next entry
  // DONE  | one-cycle done pulse
  typedef enum logic [1:0] {IDLE, CALC, WRITE, DONE} state_t;

  localparam int AW = W + GUARD;
  localparam int PW = 2 * W;
  localparam int IW = $clog2(N + 1);

  function automatic logic [N*N*W-1:0] identity();
    logic [N*N*W-1:0] m;
    m = '0;
    for (int d = 0; d < N; d++) m[d * (N + 1) * W + FRAC] = 1'b1;
    return m;
  endfunction

  localparam logic [N*N*W-1:0] IDENT = identity();

  state_t                 state_q, state_d;
  logic [N*N*W-1:0]       l_q, x_q;
  logic [IW-1:0]          i_q, j_q, k_q;
  logic signed [AW-1:0]   acc_q, acc_d, term;
  logic signed [W-1:0]    l_ik, x_kj;
  logic signed [PW-1:0]   prod, prod_sh;
  logic signed [AW:0]     sum, neg_acc;
  logic [W-1:0]           x_new;
  logic                   x_sat, last_k, row_end;

  always_comb begin
    l_ik    = l_q[(int'(i_q) * N + int'(k_q)) * W +: W];
    x_kj    = x_q[(int'(k_q) * N + int'(j_q)) * W +: W];
    prod    = l_ik * x_kj;
    prod_sh = prod >>> FRAC;
    // Terms and the running sum clamp to the accumulator range instead of wrapping.
    if (prod_sh[PW-1:AW-1] == '0 || prod_sh[PW-1:AW-1] == '1)
      term = prod_sh[AW-1:0];
    else
      term = prod_sh[PW-1] ? {1'b1, {(AW-1){1'b0}}} : {1'b0, {(AW-1){1'b1}}};
    sum = {acc_q[AW-1], acc_q} + {term[AW-1], term};
    if (sum[AW] == sum[AW-1])
      acc_d = sum[AW-1:0];
    else
      acc_d = sum[AW] ? {1'b1, {(AW-1){1'b0}}} : {1'b0, {(AW-1){1'b1}}};
    if (k_q == j_q) acc_d = term;
    neg_acc = -{acc_q[AW-1], acc_q};
    x_sat   = !(neg_acc[AW:W-1] == '0 || neg_acc[AW:W-1] == '1);
    if (x_sat)
      x_new = neg_acc[AW] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    else
      x_new = neg_acc[W-1:0];
    last_k  = (k_q == i_q - 1'b1);
    row_end = (j_q + 1'b1 == i_q);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = (N == 1) ? DONE : CALC;
      CALC:    if (last_k) state_d = WRITE;
      WRITE:   state_d = (row_end && i_q == IW'(N - 1)) ? DONE : CALC;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      l_q     <= '0;
      x_q     <= '0;
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
      acc_q   <= '0;
      ovf     <= 1'b0;
    end else if (en) begin
      state_q <= state_d;
      case (state_q)
        IDLE: if (start) begin
          l_q <= matrix;
          x_q <= IDENT;
          ovf <= 1'b0;
          i_q <= IW'(1);
          j_q <= '0;
          k_q <= '0;
        end
        CALC: begin
          acc_q <= acc_d;
          if (!last_k) k_q <= k_q + 1'b1;
        end
        WRITE: begin
          x_q[(int'(i_q) * N + int'(j_q)) * W +: W] <= x_new;
          if (x_sat) ovf <= 1'b1;
          if (row_end) begin
            i_q <= i_q + 1'b1;
            j_q <= '0;
            k_q <= '0;
          end else begin
            j_q <= j_q + 1'b1;
            k_q <= j_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy       = (state_q == CALC) || (state_q == WRITE);
  assign done       = (state_q == DONE);
  assign lt_inverse = x_q;

endmodule

// File: tb/tb_lt_inverse_seq.sv
// Directed bench for lt_inverse_seq (N=6, Q11.16): latency, results, saturation, control, reset.
module tb_lt_inverse_seq;
  localparam int N = 6, W = 27, FRAC = 16, GUARD = 4, NN = N * N * W;

  logic          clk = 1'b0, rst = 1'b0, en = 1'b1, start = 1'b0;
  logic [NN-1:0] matrix = '0;
  logic [NN-1:0] lt_inverse, exp_m;
  logic          busy, done, ovf;
  int            n_cmp = 0, n_bad = 0, edges;

  lt_inverse_seq #(.N(N), .W(W), .FRAC(FRAC), .GUARD(GUARD)) dut (
    .clk(clk), .rst(rst), .en(en), .start(start), .matrix(matrix),
    .busy(busy), .done(done), .lt_inverse(lt_inverse), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic chk_mat(input string tag, input logic [NN-1:0] expv);
    int e;
    n_cmp++;
    assert (lt_inverse === expv) else begin
      n_bad++;
      e = 0;
      while (e < N * N - 1 && lt_inverse[e*W +: W] === expv[e*W +: W]) e++;
      $error("FAIL %s: X[%0d][%0d] observed %0h expected %0h", tag, e / N, e % N,
             lt_inverse[e*W +: W], expv[e*W +: W]);
    end
  endtask

  task automatic set_l(input int i, input int j, input logic [W-1:0] v);
    matrix[(i * N + j) * W +: W] = v;
  endtask

  task automatic set_x(input int i, input int j, input logic [W-1:0] v);
    exp_m[(i * N + j) * W +: W] = v;
  endtask

  task automatic ident_exp();
    exp_m = '0;
    for (int d = 0; d < N; d++) set_x(d, d, 27'h0010000);
  endtask

  task automatic subdiag_setup();
    matrix = '0;
    for (int i = 1; i < N; i++) set_l(i, i - 1, 27'h0010000);
    exp_m = '0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j <= i; j++)
        set_x(i, j, ((i - j) % 2 == 1) ? 27'h7FF0000 : 27'h0010000);
  endtask

  task automatic sat_setup();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        set_l(i, j, (j >= i) ? 27'h1234567 : 27'h0000000);
    set_l(1, 0, 27'h3FF0000);
    set_l(2, 1, 27'h0020000);
    set_l(3, 2, 27'h0020000);
    ident_exp();
    set_x(1, 0, 27'h4010000);
    set_x(2, 0, 27'h3FFFFFF);
    set_x(2, 1, 27'h7FE0000);
    set_x(3, 0, 27'h4000000);
    set_x(3, 1, 27'h0040000);
    set_x(3, 2, 27'h7FE0000);
  endtask

  task automatic half_setup();
    matrix = '0;
    set_l(1, 0, 27'h0008000);
    ident_exp();
    set_x(1, 0, 27'h7FF8000);
  endtask

  // Called at posedge+1; edges counts every clock edge from the accepting one.
  task automatic run_op(input int restart_at, input int pause_at, input int pause_len,
                        input bit scramble, output int n);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 1;
    while (done !== 1'b1 && n < 300) begin
      if (n == restart_at) begin
        chk("busy_at_restart", busy, 1);
        start = 1'b1;
      end else if (n == restart_at + 1) start = 1'b0;
      if (n == pause_at) en = 1'b0;
      else if (n == pause_at + pause_len) en = 1'b1;
      if (scramble && n == 2) matrix = '1;
      @(posedge clk); #1;
      n++;
    end
    chk("done_seen", done, 1);
  endtask

  initial begin
    #2;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ovf", ovf, 0);
    chk_mat("rst_x", '0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    matrix = '0;
    for (int d = 0; d < N; d++) set_l(d, d, 27'h0010000);
    ident_exp();
    run_op(0, 0, 0, 1'b0, edges);
    chk("t1_latency", edges, 51);
    chk("t1_busy_at_done", busy, 0);
    chk_mat("t1_x", exp_m);
    chk("t1_ovf", ovf, 0);
    @(posedge clk); #1;
    chk("t1_done_pulse", done, 0);

    subdiag_setup();
    run_op(0, 0, 0, 1'b0, edges);
    chk("t2_latency", edges, 51);
    chk_mat("t2_x", exp_m);
    chk("t2_x50", lt_inverse[(5 * N) * W +: W], 27'h7FF0000);
    chk("t2_ovf", ovf, 0);
    @(posedge clk); #1;

    sat_setup();
    run_op(0, 0, 0, 1'b0, edges);
    chk("sat_latency", edges, 51);
    chk_mat("sat_x", exp_m);
    chk("sat_ovf", ovf, 1);
    @(posedge clk); #1;
    chk("sat_ovf_hold", ovf, 1);
    chk_mat("sat_x_hold", exp_m);

    half_setup();
    run_op(0, 0, 0, 1'b0, edges);
    chk("t3_latency", edges, 51);
    chk_mat("t3_x", exp_m);
    chk("t3_ovf_cleared", ovf, 0);
    @(posedge clk); #1;

    subdiag_setup();
    run_op(20, 25, 10, 1'b1, edges);
    chk("ctl_latency", edges, 61);
    chk_mat("ctl_x", exp_m);
    @(posedge clk); #1;
    chk("ctl_done_pulse", done, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("ctl_no_rerun", busy, 0);
    chk_mat("ctl_x_hold", exp_m);

    sat_setup();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (29) @(posedge clk);
    #1;
    chk("rst_mid_busy_pre", busy, 1);
    chk("rst_mid_ovf_pre", ovf, 1);
    rst = 1'b0;
    #1;
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_done", done, 0);
    chk("rst_mid_ovf", ovf, 0);
    chk_mat("rst_mid_x", '0);
    @(posedge clk); #1;
    rst = 1'b1;
    half_setup();
    run_op(0, 0, 0, 1'b0, edges);
    chk("post_rst_latency", edges, 51);
    chk_mat("post_rst_x", exp_m);
    chk("post_rst_ovf", ovf, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
